ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the five-stage pipelined CPU. It consumes the multiply/divide request presented at the ID/EX register outputs, computes the result over 32 iteration cycles, and holds the pipeline with a stall request until the HI/LO result is ready. It is the consumer end of the ID/EX `is_mul` path. The hazard unit uses `stall_req` to freeze PC, IF/ID and ID/EX.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `ITER`, default 32: number of iteration cycles. Must equal `XLEN`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  multiply/divide instruction valid in EX (driven from the ID/EX register).
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `flush`  in  1  synchronous abort from branch/exception logic.
- `stall_req`  out  1  combinational request to freeze the upstream pipeline.
- `busy`  out  1  registered; high while in RUN.
- `done`  out  1  registered; one-cycle pulse when `hi`/`lo` update.
- `hi`  out  32  HI register: upper product, or remainder.
- `lo`  out  32  LO register: lower product, or quotient.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN** when `start && !flush`.
  - On entry, latch `op`.
  - For signed ops, latch |a| and |b| and the result signs: product sign = sign(a) XOR sign(b); quotient sign likewise; remainder sign = sign(a).
  - Load the 5-bit counter with `ITER-1`.
- **RUN:**
  - Multiply: one shift-add step per cycle on a 64-bit accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - The counter decrements each cycle. When it reaches 0 and that step completes, go to DONE.
- **DONE:**
  - Write `hi`/`lo` with the sign-corrected result.
  - Pulse `done`.
  - Return to IDLE unconditionally. `start` is not re-sampled in DONE, because the same instruction is still in ID/EX that cycle.
- **Stall:** `stall_req = (IDLE && start) || RUN`. It is low in DONE, so ID/EX advances at the end of the DONE cycle.
- **Divide by zero:** `lo = 32'hFFFFFFFF`, `hi = a` (original, unsigned interpretation). Full latency still applies.
- **Signed overflow:** DIV of 0x80000000 by -1 gives `lo = 0x80000000`, `hi = 0`.
- **Flush:**
  - In any state, go to IDLE next cycle.
  - `hi`/`lo` are not written and `done` stays low.
  - Flush has priority over `start` and over completion.
- **Reset:** on `rst`, state = IDLE, counter = 0, and `busy`, `done`, `hi`, `lo` and the accumulator are all 0. This holds mid-RUN as well.

## Timing
- `start` is sampled at edge 0. Edges 1..32 perform the RUN steps. Edge 33 is the DONE update: `hi`/`lo`/`done` are visible after edge 33.
- Total stall: 33 cycles (the cycle `start` is first seen, plus 32 RUN cycles).
- `done` is high for exactly one cycle. `busy` is high for exactly 32 cycles.
- `hi`/`lo` hold their value between operations.
- `start` deasserting during RUN is ignored; only `flush` aborts.

## Configuration
- **`EX_MULDIV_DIV_EN` defined:** DIV/DIVU are implemented as above.
- **`EX_MULDIV_DIV_EN` undefined:**
  - The divide datapath is removed.
  - `op[1]=1` goes IDLE → DONE directly: stall of 1 cycle, `done` pulses, `hi`/`lo` unchanged.
  - MULT/MULTU behaviour is unchanged.

## Structure
- **Package `ex_muldiv_pkg`:**
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`
  - state enum `{S_IDLE, S_RUN, S_DONE}`
  - `ITER` constant
  - divide-by-zero result constants
- **Sub-module `muldiv_step`:** combinational single-iteration datapath (shift-add or shift-subtract) taking accumulator and operand and returning the next accumulator. The top level holds the FSM, counter, sign fix-up and HI/LO registers.

## Test plan
- MULTU a=7, b=6 → `stall_req` high 33 cycles; `done` at edge 33; `hi=0`, `lo=42`.
- MULT a=0x80000000, b=2 → `hi=0xFFFFFFFF`, `lo=0x00000000`. MULT a=-1, b=-1 → `hi=0`, `lo=1`.
- DIVU 100/7 → `lo=14`, `hi=2`. DIV -7/2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- DIVU a=0x1234, b=0 → `lo=0xFFFFFFFF`, `hi=0x1234`, after full 33-cycle latency.
- MULTU 3×5 with `flush` at RUN cycle 10 → IDLE next cycle; `done` never pulses; `hi`/`lo` retain prior values. A following MULTU 2×2 gives `lo=4`.
- `rst` asserted at RUN cycle 20 → all outputs 0 immediately. With `EX_MULDIV_DIV_EN` undefined, DIV → `done` after 1 cycle and `hi`/`lo` unchanged.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared constants and types for the EX-stage multiply/divide unit.
// Optional divide datapath is controlled by the EX_MULDIV_DIV_EN macro.
package ex_muldiv_pkg;

  localparam int unsigned ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // Divide by zero: quotient saturates to all ones, remainder is the raw dividend.
  localparam logic [31:0] DIVZ_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Multiply: shift-add on {partial product, multiplier}.
// Divide (only with EX_MULDIV_DIV_EN): restoring shift-subtract on {remainder, quotient}.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
`ifdef EX_MULDIV_DIV_EN
  input  logic              i_div,
`endif
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
`ifdef EX_MULDIV_DIV_EN
  logic [XLEN:0] w_rem;
  logic [XLEN:0] w_diff;
`endif

  // Next accumulator for one multiply or divide step
  always_comb begin
    w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opd} : '0);
    o_acc = {w_sum, i_acc[XLEN-1:1]};
`ifdef EX_MULDIV_DIV_EN
    w_rem  = i_acc[2*XLEN-1:XLEN-1];
    w_diff = w_rem - {1'b0, i_opd};
    if (i_div) begin
      if (w_diff[XLEN]) o_acc = {i_acc[2*XLEN-2:0], 1'b0};
      else              o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32-cycle multiply/divide unit in EX with pipeline stall.
// Define EX_MULDIV_DIV_EN to include DIV/DIVU; otherwise divide ops complete
// in one cycle with HI/LO left unchanged.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import ex_muldiv_pkg::*;

  localparam int unsigned CW = $clog2(ITER);

  state_e             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_opd;
  logic               r_div;
  logic               r_neg_lo;
  logic               r_busy, r_done;
  logic [XLEN-1:0]    r_hi, r_lo;
`ifdef EX_MULDIV_DIV_EN
  logic               r_neg_hi;
  logic               r_bz;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    w_quo, w_rem;
`endif

  logic               w_signed, w_isdiv, w_sa, w_sb;
  logic [XLEN-1:0]    w_abs_a, w_abs_b;
  logic [2*XLEN-1:0]  w_step, w_prod;

  muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef EX_MULDIV_DIV_EN
    .i_div (r_div),
`endif
    .i_acc (r_acc),
    .i_opd (r_opd),
    .o_acc (w_step)
  );

  // Operand decode, magnitudes and sign-corrected results
  always_comb begin
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_isdiv  = (op == OP_DIV)  || (op == OP_DIVU);
    w_sa     = w_signed && a[XLEN-1];
    w_sb     = w_signed && b[XLEN-1];
    w_abs_a  = w_sa ? -a : a;
    w_abs_b  = w_sb ? -b : b;
    w_prod   = r_neg_lo ? -r_acc : r_acc;
`ifdef EX_MULDIV_DIV_EN
    w_quo    = r_neg_lo ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem    = r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush wins over start and completion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start && !flush) begin
`ifdef EX_MULDIV_DIV_EN
        w_next = S_RUN;
`else
        w_next = w_isdiv ? S_DONE : S_RUN;
`endif
      end
      S_RUN:  if (flush) w_next = S_IDLE;
              else if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall request: holds the pipeline from first sight of start through RUN
  always_comb begin
    stall_req = ((r_state == S_IDLE) && start) || (r_state == S_RUN);
  end

  // Datapath: operand latch, iteration, HI/LO writeback, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef EX_MULDIV_DIV_EN
      r_neg_hi <= 1'b0;
      r_bz     <= 1'b0;
      r_a      <= '0;
`endif
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (r_state == S_DONE) && !flush;
      unique case (r_state)
        S_IDLE: if (start && !flush) begin
          r_div    <= w_isdiv;
          r_neg_lo <= w_sa ^ w_sb;
          r_cnt    <= CW'(ITER - 1);
`ifdef EX_MULDIV_DIV_EN
          r_neg_hi <= w_sa;
          r_bz     <= (b == '0);
          r_a      <= a;
          r_acc    <= {{XLEN{1'b0}}, (w_isdiv ? w_abs_a : w_abs_b)};
          r_opd    <= w_isdiv ? w_abs_b : w_abs_a;
`else
          r_acc    <= {{XLEN{1'b0}}, w_abs_b};
          r_opd    <= w_abs_a;
`endif
        end
        S_RUN: if (!flush) begin
          r_acc <= w_step;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DONE: if (!flush) begin
`ifdef EX_MULDIV_DIV_EN
          if (r_div) begin
            if (r_bz) begin
              r_hi <= r_a;
              r_lo <= DIVZ_LO;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
`else
          if (!r_div) {r_hi, r_lo} <= w_prod;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed + scoreboard bench for ex_muldiv_unit.
// Covers both builds: EX_MULDIV_DIV_EN defined or undefined.
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall_req, busy, done;
  logic [31:0] hi, lo;

  ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (o)
      OP_MULT:  p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      default: begin
`ifdef EX_MULDIV_DIV_EN
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (o == OP_DIV) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
          else p = {$signed(x) % $signed(y), $signed(x) / $signed(y)};
        end else p = {x % y, x / y};
`else
        p = {m_hi, m_lo};
`endif
      end
    endcase
    return p;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", {63'b0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) check("hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int exp_stall, input int exp_busy,
                        input string tag);
    int sc, bc;
    bit ended;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(exp);
    #1;
    sc = 0; bc = 0; ended = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!stall_req) begin
        ended = 1'b1;
        break;
      end
      sc++;
      if (busy) bc++;
      @(negedge clk);
    end
    check({tag, "_stall_ends"}, {63'b0, ended}, 64'd1);
    check({tag, "_stall_cycles"}, 64'(sc), 64'(exp_stall));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    check({tag, "_done_pre"}, {63'b0, done}, 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'b0, done}, 64'd1);
    start = 1'b0;
    {m_hi, m_lo} = exp;
    @(negedge clk);
    check({tag, "_done_clear"}, {63'b0, done}, 64'd0);
    check({tag, "_hilo_hold"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {61'b0, done, busy, stall_req}, 64'd0);
    rst = 1'b0;

    run_op(OP_MULTU, 32'd7, 32'd6, {32'd0, 32'd42}, 33, 32, "multu_7x6");
    run_op(OP_MULT, 32'h8000_0000, 32'd2, {32'hFFFF_FFFF, 32'h0000_0000}, 33, 32, "mult_min_x2");
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1}, 33, 32, "mult_m1_m1");

`ifdef EX_MULDIV_DIV_EN
    run_op(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 32, "divu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32, "div_m7_2");
    run_op(OP_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 33, 32, "divu_by0");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 32, "div_ovf");
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 33, 32, "div_neg_by0");
    for (int i = 0; i < 4; i++) begin
      ro = 2'b10 | 2'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom_range(1, 5000);
      if (i[0]) ry = -ry;
      run_op(ro, rx, ry, model(ro, rx, ry), 33, 32, "div_rand");
    end
`else
    run_op(OP_DIV, 32'd100, 32'd7, {m_hi, m_lo}, 1, 0, "div_disabled");
    run_op(OP_DIVU, 32'h1234, 32'd0, {m_hi, m_lo}, 1, 0, "divu_disabled");
`endif

    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      run_op(ro, rx, ry, model(ro, rx, ry), 33, 32, "mul_rand");
    end

    // Flush during RUN cycle 10: no writeback, no done
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    repeat (10) @(negedge clk);
    check("flush_busy_before", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_idle", {62'b0, busy, stall_req}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});
    run_op(OP_MULTU, 32'd2, 32'd2, {32'd0, 32'd4}, 33, 32, "multu_after_flush");

    // Async reset during RUN cycle 20; start dropped mid-run is ignored
    @(negedge clk);
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_busy_before", {63'b0, busy}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_flags", {61'b0, done, busy, stall_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    check("rst_after_hilo", {hi, lo}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
